// File: rtl/ov7670_pixel_capture_pkg.sv
// Shared types and constants for the OV7670 pixel capture block.
package ov7670_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_BLANK = 2'd1,
    ST_WAIT_FRAME = 2'd2,
    ST_ACTIVE     = 2'd3
  } cap_state_t;

  localparam int DEF_H_PIXELS = 320;
  localparam int DEF_V_LINES  = 240;
  localparam int RGB565_W     = 16;

endpackage

// File: rtl/ov7670_pixel_capture_if.sv
// Frame-buffer write bus: one registered strobe with address and RGB565 data.
interface ov7670_pix_if #(
  parameter int ADDR_W = 17
);
  logic                                 pix_we;
  logic [ADDR_W-1:0]                    pix_addr;
  logic [ov7670_cap_pkg::RGB565_W-1:0]  pix_data;

  modport master (output pix_we, pix_addr, pix_data);
  modport slave  (input  pix_we, pix_addr, pix_data);
endinterface

// File: rtl/ov7670_pixel_capture_cam_sig_sync.sv
// 2-FF synchronizer plus one delay stage; optional registered rise/fall strobes
// aligned with the delayed output.
module cam_sig_sync #(
  parameter int W     = 1,
  parameter bit EDGES = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_q = r_s3;

  // Strobes are registered so they line up with r_s3 carrying the new level.
  generate
    if (EDGES) begin : g_edge
      for (genvar gi = 0; gi < W; gi++) begin : g_bit
        logic r_rise;
        logic r_fall;
        always_ff @(posedge clk) begin
          if (reset) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
          end else begin
            r_rise <= r_s2[gi] & ~r_s3[gi];
            r_fall <= ~r_s2[gi] & r_s3[gi];
          end
        end
        assign o_rise[gi] = r_rise;
        assign o_fall[gi] = r_fall;
      end
    end else begin : g_no_edge
      assign o_rise = '0;
      assign o_fall = '0;
    end
  endgenerate

endmodule

// File: rtl/ov7670_pixel_capture.sv
// Aligns to full OV7670 frames after init and turns byte pairs into RGB565
// frame-buffer writes at address line_base + x.
module ov7670_pixel_capture
  import ov7670_cap_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_LINES  = DEF_V_LINES,
  parameter int ADDR_W   = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_done,
  input  logic             cam_pclk,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic [7:0]       cam_data,
  ov7670_pix_if.master     pix,
  output logic             frame_start,
  output logic             frame_done,
  output logic             capturing,
  output logic             fmt_err
);

  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_LINES + 2);
  localparam logic [XW-1:0]     X_LIM  = XW'(H_PIXELS);
  localparam logic [YW-1:0]     Y_LIM  = YW'(V_LINES);
  localparam logic [YW-1:0]     Y_SAT  = YW'(V_LINES + 1);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIXELS);

  logic [2:0] w_ctl_q;
  logic [2:0] w_ctl_rise;
  logic [2:0] w_ctl_fall;
  logic [7:0] w_data;

  cam_sig_sync #(.W(3), .EDGES(1'b1)) u_ctl_sync (
    .clk    (clk),
    .reset  (reset),
    .i_d    ({cam_vsync, cam_href, cam_pclk}),
    .o_q    (w_ctl_q),
    .o_rise (w_ctl_rise),
    .o_fall (w_ctl_fall)
  );

  cam_sig_sync #(.W(8), .EDGES(1'b0)) u_data_sync (
    .clk    (clk),
    .reset  (reset),
    .i_d    (cam_data),
    .o_q    (w_data),
    .o_rise (),
    .o_fall ()
  );

  logic w_vsync, w_vs_rise, w_vs_fall, w_href, w_href_fall, w_pclk_rise;
  assign w_vsync     = w_ctl_q[2];
  assign w_vs_rise   = w_ctl_rise[2];
  assign w_vs_fall   = w_ctl_fall[2];
  assign w_href      = w_ctl_q[1];
  assign w_href_fall = w_ctl_fall[1];
  assign w_pclk_rise = w_ctl_rise[0];

  cap_state_t r_state, w_state_n;

  logic [XW-1:0]       r_x, w_x_n;
  logic [YW-1:0]       r_y, w_y_n;
  logic [ADDR_W-1:0]   r_base, w_base_n;
  logic                r_phase, w_phase_n;
  logic [7:0]          r_hi, w_hi_n;
  logic                r_pix_we, w_we_n;
  logic [ADDR_W-1:0]   r_pix_addr, w_addr_n;
  logic [RGB565_W-1:0] r_pix_data, w_data_n;
  logic                r_fmt_err, w_err_n;
  logic                r_frame_start, w_fs_n;
  logic                r_frame_done, w_fd_n;
  logic                w_close;
  logic                w_capturing;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE:       if (init_done) w_state_n = ST_WAIT_BLANK;
      ST_WAIT_BLANK: if (w_vsync)   w_state_n = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (w_vs_fall) w_state_n = ST_ACTIVE;
      ST_ACTIVE:     if (w_vs_rise) w_state_n = ST_WAIT_FRAME;
      default:                      w_state_n = ST_IDLE;
    endcase
    if (!init_done) w_state_n = ST_IDLE;
  end

  always_comb begin
    w_capturing = (r_state == ST_ACTIVE);
  end

  // Byte, then line close, then frame-end check: later steps see earlier updates.
  always_comb begin
    w_x_n     = r_x;
    w_y_n     = r_y;
    w_base_n  = r_base;
    w_phase_n = r_phase;
    w_hi_n    = r_hi;
    w_we_n    = 1'b0;
    w_addr_n  = r_pix_addr;
    w_data_n  = r_pix_data;
    w_err_n   = r_fmt_err;
    w_fs_n    = 1'b0;
    w_fd_n    = 1'b0;
    w_close   = 1'b0;
    if (init_done && r_state == ST_WAIT_FRAME && w_vs_fall) begin
      w_x_n     = '0;
      w_y_n     = '0;
      w_base_n  = '0;
      w_phase_n = 1'b0;
      w_fs_n    = 1'b1;
    end
    if (init_done && r_state == ST_ACTIVE) begin
      if (w_pclk_rise && w_href) begin
        if (!r_phase) begin
          w_hi_n    = w_data;
          w_phase_n = 1'b1;
        end else begin
          w_phase_n = 1'b0;
          if (r_x < X_LIM && r_y < Y_LIM) begin
            w_we_n   = 1'b1;
            w_addr_n = r_base + ADDR_W'(r_x);
            w_data_n = {r_hi, w_data};
            w_x_n    = r_x + 1'b1;
          end else begin
            w_err_n = 1'b1;
          end
        end
      end
      w_close = w_href_fall | (w_vs_rise & w_href);
      if (w_close) begin
        if (w_phase_n) w_err_n = 1'b1;
        w_phase_n = 1'b0;
        w_x_n     = '0;
        if (r_y < Y_LIM)  w_base_n = r_base + H_STEP;
        if (r_y != Y_SAT) w_y_n    = r_y + 1'b1;
      end
      if (w_vs_rise) begin
        if (w_y_n == Y_LIM) w_fd_n  = 1'b1;
        else                w_err_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x           <= '0;
      r_y           <= '0;
      r_base        <= '0;
      r_phase       <= 1'b0;
      r_hi          <= '0;
      r_pix_we      <= 1'b0;
      r_pix_addr    <= '0;
      r_pix_data    <= '0;
      r_fmt_err     <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_x           <= w_x_n;
      r_y           <= w_y_n;
      r_base        <= w_base_n;
      r_phase       <= w_phase_n;
      r_hi          <= w_hi_n;
      r_pix_we      <= w_we_n;
      r_pix_addr    <= w_addr_n;
      r_pix_data    <= w_data_n;
      r_fmt_err     <= w_err_n;
      r_frame_start <= w_fs_n;
      r_frame_done  <= w_fd_n;
    end
  end

  assign pix.pix_we   = r_pix_we;
  assign pix.pix_addr = r_pix_addr;
  assign pix.pix_data = r_pix_data;
  assign frame_start  = r_frame_start;
  assign frame_done   = r_frame_done;
  assign capturing    = w_capturing;
  assign fmt_err      = r_fmt_err;

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Directed bench for ov7670_pixel_capture with H_PIXELS=4, V_LINES=2; writes are
// logged at negedge and compared against a hand-computed table.
module tb_ov7670_pixel_capture;
  import ov7670_cap_pkg::*;

  localparam int HP = 4;
  localparam int VL = 2;
  localparam int AW = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_done = 1'b0;
  logic       cam_pclk = 1'b0;
  logic       cam_vsync = 1'b0;
  logic       cam_href = 1'b0;
  logic [7:0] cam_data = 8'h00;
  logic       frame_start, frame_done, capturing, fmt_err;

  ov7670_pix_if #(.ADDR_W(AW)) pix_bus ();

  ov7670_pixel_capture #(.H_PIXELS(HP), .V_LINES(VL), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .init_done   (init_done),
    .cam_pclk    (cam_pclk),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .pix         (pix_bus.master),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .capturing   (capturing),
    .fmt_err     (fmt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t exp_tbl[19];

  logic [AW-1:0] log_addr[256];
  logic [15:0]   log_data[256];
  time           log_t[256];
  int            n_we = 0;
  int            n_fs = 0;
  int            n_fd = 0;
  int            n_b2b = 0;
  logic          prev_we = 1'b0;
  time           t_b1 = 0;

  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) begin
    if (pix_bus.pix_we === 1'b1) begin
      if (n_we < 256) begin
        log_addr[n_we] = pix_bus.pix_addr;
        log_data[n_we] = pix_bus.pix_data;
        log_t[n_we]    = $time;
      end
      n_we = n_we + 1;
      if (prev_we) n_b2b = n_b2b + 1;
    end
    if (frame_start === 1'b1) n_fs = n_fs + 1;
    if (frame_done === 1'b1)  n_fd = n_fd + 1;
    prev_we = (pix_bus.pix_we === 1'b1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  task automatic check_writes(input string tag, input int s, input int t, input int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s addr[%0d]", tag, k), 32'(log_addr[s+k]), 32'(exp_tbl[t+k].addr));
      chk($sformatf("%s data[%0d]", tag, k), 32'(log_data[s+k]), 32'(exp_tbl[t+k].data));
    end
  endtask

  function automatic logic [7:0] bv(input int l, input int i);
    return 8'(171 + 34 * i + 16 * l);
  endfunction

  task automatic cam_byte(input logic [7:0] b, input bit rec);
    cam_pclk = 1'b0;
    cam_data = b;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b1;
    if (rec) t_b1 = $time;
    repeat (2) @(negedge clk);
  endtask

  task automatic cam_bytes(input int l, input int from, input int to);
    for (int i = from; i < to; i++) cam_byte(bv(l, i), i == 1);
  endtask

  task automatic line_end();
    cam_href = 1'b0;
    cam_pclk = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cam_line(input int l, input int nb);
    cam_href = 1'b1;
    cam_bytes(l, 0, nb);
    line_end();
  endtask

  task automatic vs_pulse();
    cam_vsync = 1'b1;
    repeat (6) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    init_done = 1'b0;
    cam_href  = 1'b0;
    cam_pclk  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
    #1;
  endtask

  int s, s2, fs0, fd0;
  time t0;

  initial begin
    // Line 0 bytes AB CD EF 11 33 55 77 99, line 1 BB DD FF 21 43 65 87 A9.
    exp_tbl[0]  = '{8'd0, 16'hABCD};
    exp_tbl[1]  = '{8'd1, 16'hEF11};
    exp_tbl[2]  = '{8'd2, 16'h3355};
    exp_tbl[3]  = '{8'd3, 16'h7799};
    exp_tbl[4]  = '{8'd4, 16'hBBDD};
    exp_tbl[5]  = '{8'd5, 16'hFF21};
    exp_tbl[6]  = '{8'd6, 16'h4365};
    exp_tbl[7]  = '{8'd7, 16'h87A9};
    exp_tbl[8]  = '{8'd0, 16'hABCD};
    exp_tbl[9]  = '{8'd1, 16'hEF11};
    exp_tbl[10] = '{8'd2, 16'h3355};
    exp_tbl[11] = '{8'd4, 16'hBBDD};
    exp_tbl[12] = '{8'd5, 16'hFF21};
    exp_tbl[13] = '{8'd6, 16'h4365};
    exp_tbl[14] = '{8'd7, 16'h87A9};
    exp_tbl[15] = '{8'd0, 16'hBBDD};
    exp_tbl[16] = '{8'd1, 16'hFF21};
    exp_tbl[17] = '{8'd2, 16'h4365};
    exp_tbl[18] = '{8'd3, 16'h87A9};

    @(negedge clk);
    do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset pix_we", 32'(pix_bus.pix_we), 0);
    chk("reset pix_addr", 32'(pix_bus.pix_addr), 0);
    chk("reset pix_data", 32'(pix_bus.pix_data), 0);
    chk("reset frame_start", 32'(frame_start), 0);
    chk("reset frame_done", 32'(frame_done), 0);
    chk("reset capturing", 32'(capturing), 0);
    chk("reset fmt_err", 32'(fmt_err), 0);
    reset = 1'b0;

    // Basic 2x4 frame
    do_reset();
    init_done = 1'b1;
    fs0 = n_fs; fd0 = n_fd;
    vs_pulse();
    chk("basic capturing", 32'(capturing), 1);
    s = n_we;
    cam_line(0, 8);
    t0 = t_b1;
    cam_line(1, 8);
    frame_end();
    settle();
    chk("basic writes", 32'(n_we - s), 8);
    check_writes("basic", s, 0, 8);
    chk("basic latency", 32'(log_t[s] - t0), 40);
    chk("basic frame_start", 32'(n_fs - fs0), 1);
    chk("basic frame_done", 32'(n_fd - fd0), 1);
    chk("basic fmt_err", 32'(fmt_err), 0);
    chk("basic capturing end", 32'(capturing), 0);

    // Init gating with a frame already in progress
    do_reset();
    fs0 = n_fs; fd0 = n_fd; s = n_we;
    cam_vsync = 1'b0;
    cam_href = 1'b1;
    cam_bytes(0, 0, 4);
    init_done = 1'b1;
    cam_bytes(0, 4, 8);
    line_end();
    cam_line(1, 8);
    chk("gate no early writes", 32'(n_we - s), 0);
    vs_pulse();
    cam_line(0, 8);
    settle();
    chk("gate writes", 32'(n_we - s), 4);
    check_writes("gate", s, 0, 4);
    chk("gate frame_start", 32'(n_fs - fs0), 1);
    chk("gate frame_done", 32'(n_fd - fd0), 0);
    chk("gate fmt_err", 32'(fmt_err), 0);

    // Odd byte count on line 0
    do_reset();
    init_done = 1'b1;
    fd0 = n_fd;
    vs_pulse();
    s = n_we;
    cam_line(0, 7);
    cam_line(1, 8);
    frame_end();
    settle();
    chk("odd writes", 32'(n_we - s), 7);
    check_writes("odd", s, 8, 7);
    chk("odd fmt_err", 32'(fmt_err), 1);
    chk("odd frame_done", 32'(n_fd - fd0), 1);

    // Overlong line and overlong frame
    do_reset();
    init_done = 1'b1;
    fd0 = n_fd;
    vs_pulse();
    s = n_we;
    cam_line(0, 12);
    chk("long line fmt_err", 32'(fmt_err), 1);
    cam_line(1, 8);
    cam_line(2, 8);
    frame_end();
    settle();
    chk("long writes", 32'(n_we - s), 8);
    check_writes("long", s, 0, 8);
    chk("long frame_done", 32'(n_fd - fd0), 0);

    // Short frame, then a fresh frame from address 0
    do_reset();
    init_done = 1'b1;
    fs0 = n_fs; fd0 = n_fd;
    vs_pulse();
    s = n_we;
    cam_line(0, 8);
    frame_end();
    chk("short frame_done", 32'(n_fd - fd0), 0);
    chk("short fmt_err", 32'(fmt_err), 1);
    cam_vsync = 1'b0;
    repeat (6) @(negedge clk);
    cam_line(1, 8);
    settle();
    chk("short writes", 32'(n_we - s), 8);
    check_writes("short f0", s, 0, 4);
    check_writes("short f1", s + 4, 15, 4);
    chk("short frame_start", 32'(n_fs - fs0), 2);

    // Reset and init_done aborts mid-line
    do_reset();
    init_done = 1'b1;
    vs_pulse();
    s = n_we;
    cam_href = 1'b1;
    cam_bytes(0, 0, 4);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort rst pix_we", 32'(pix_bus.pix_we), 0);
    chk("abort rst pix_addr", 32'(pix_bus.pix_addr), 0);
    chk("abort rst pix_data", 32'(pix_bus.pix_data), 0);
    chk("abort rst capturing", 32'(capturing), 0);
    reset = 1'b0;
    s2 = n_we;
    cam_bytes(0, 4, 8);
    line_end();
    cam_line(1, 8);
    chk("abort rst no writes", 32'(n_we - s2), 0);
    vs_pulse();
    cam_line(0, 8);
    cam_href = 1'b1;
    cam_bytes(1, 0, 4);
    repeat (4) @(negedge clk);
    init_done = 1'b0;
    @(negedge clk);
    chk("abort init pix_we", 32'(pix_bus.pix_we), 0);
    chk("abort init capturing", 32'(capturing), 0);
    s2 = n_we;
    cam_bytes(1, 4, 8);
    line_end();
    init_done = 1'b1;
    cam_line(0, 8);
    chk("abort init no writes", 32'(n_we - s2), 0);
    vs_pulse();
    cam_line(0, 8);
    settle();
    chk("abort writes", 32'(n_we - s), 12);
    check_writes("abort pre", s, 0, 2);
    check_writes("abort resume", s + 2, 0, 4);
    check_writes("abort line1", s + 6, 4, 2);
    check_writes("abort restart", s + 8, 0, 4);

    chk("no back-to-back pix_we", 32'(n_b2b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ov7670_pixel_capture.md
# ov7670_pixel_capture

Captures the OV7670 parallel pixel stream once camera register initialisation has finished, and turns it into frame-buffer write transactions. It sits directly downstream of the camera init/SCCB stage: it stays idle until `init_done` is high, then aligns to the next full frame and assembles byte pairs into RGB565 pixels. Camera signals are oversampled in the system clock domain, so the block has a single clock.

## Interface
Parameters:
- `H_PIXELS`, 320: active pixels per line.
- `V_LINES`, 240: active lines per frame.
- `ADDR_W`, 17: frame-buffer address width. Must satisfy 2^ADDR_W ≥ H_PIXELS·V_LINES.

Ports:
- `clk`  in  1  system clock. Must be ≥ 4× the camera PCLK frequency.
- `reset`  in  1  synchronous, active-high reset.
- `init_done`  in  1  level from the init stage; capture is enabled only while it is high.
- `cam_pclk`  in  1  camera pixel clock, asynchronous.
- `cam_vsync`  in  1  camera VSYNC, asynchronous; high during vertical blanking.
- `cam_href`  in  1  camera HREF, asynchronous; high while line bytes are valid.
- `cam_data`  in  8  camera data bus, asynchronous.
- `pix_we`  out  1  one-cycle write strobe.
- `pix_addr`  out  ADDR_W  write address, equal to y·H_PIXELS + x.
- `pix_data`  out  16  RGB565 pixel: first byte forms [15:8], second byte forms [7:0].
- `frame_start`  out  1  one-cycle pulse when capture of a frame begins.
- `frame_done`  out  1  one-cycle pulse when a frame completes normally.
- `capturing`  out  1  high while in ST_ACTIVE.
- `fmt_err`  out  1  sticky error flag; cleared only by `reset`.

## Operation
- All outputs reset to 0. State resets to ST_IDLE.
- `cam_pclk`, `cam_vsync`, `cam_href` and `cam_data` each pass through a 2-FF synchronizer. A third register stage provides rising- and falling-edge detection. Data is taken from the same pipeline stage as the PCLK rising-edge detect.
- States:
  - ST_IDLE: wait for `init_done`=1, then go to ST_WAIT_BLANK.
  - ST_WAIT_BLANK: wait for synced VSYNC=1, then go to ST_WAIT_FRAME. This discards any partial frame already in progress.
  - ST_WAIT_FRAME: on VSYNC falling edge, clear x, line base and y, pulse `frame_start`, and go to ST_ACTIVE.
  - ST_ACTIVE:
    - On each PCLK rising edge with HREF=1, toggle the byte phase. Phase 0 latches the high byte. Phase 1 forms the pixel.
    - If x < H_PIXELS and y < V_LINES: write the pixel and increment x. Otherwise drop the pixel and set `fmt_err`.
    - On HREF falling edge: if byte phase = 1 (odd byte count), drop the half pixel and set `fmt_err`. Then reset phase and x, add H_PIXELS to line base, and increment y.
    - On VSYNC rising edge: if y == V_LINES, pulse `frame_done`; otherwise set `fmt_err`. Then go to ST_WAIT_FRAME.
- `pix_addr` = line base + x, computed with an adder and no multiplier. Short lines therefore never misalign later lines.
- `init_done` falling in any state: go to ST_IDLE immediately. No `frame_done` pulse is issued for the aborted frame, and no further `pix_we` is asserted.
- `reset` mid-frame: everything clears. Capture restarts via ST_WAIT_BLANK.

## Timing
- Latency from the external PCLK rising edge of the second byte to `pix_we`: 4 clk (2 sync + 1 edge + 1 output register). Fixed.
- `pix_we`, `pix_addr` and `pix_data` are registered and change together. `pix_we` is never high on two consecutive cycles, because clk ≥ 4× PCLK.
- `frame_start` is registered and asserted 1 clk after the VSYNC falling edge is detected.
- `frame_done` is registered and asserted 1 clk after the VSYNC rising edge is detected.
- Same-cycle events:
  - HREF falling edge and a PCLK edge in the same cycle: the PCLK byte is processed first, then the line close.
  - VSYNC rising edge while HREF=1: the line is closed (counted) before the frame-end check.
- No back-pressure. The consumer must accept one write every 2 PCLK periods.

## Structure
- Package `ov7670_cap_pkg` holds:
  - the state typedef `cap_state_t`;
  - default `H_PIXELS` / `V_LINES` localparams;
  - `RGB565_W` = 16.
- Sub-module `cam_sig_sync`: a parameterised-width 2-FF synchronizer plus one delay stage, outputting the synced value and rise/fall strobes. Instantiate it once for the 3 control lines and once for data (data needs no strobe outputs).

## Test plan
- Basic frame: init_done=1, PCLK at clk/4, 2 lines × 4 pixels with bytes 0xAB,0xCD,… and parameters set to H_PIXELS=4, V_LINES=2 → exactly 8 `pix_we`; first write addr 0 with data 0xABCD; addr 4 at the start of line 1; one `frame_done`; `fmt_err`=0.
- Init gating and partial-frame discard: stream already mid-frame when init_done rises → no writes until the next VSYNC high→low, then `frame_start` fires and addr starts at 0.
- Odd byte line: line 0 has 7 bytes → 3 writes, `fmt_err`=1, line 1 starts at addr H_PIXELS.
- Overlong line and frame: a 6-pixel line with H_PIXELS=4 → pixels 4–5 dropped and `fmt_err` set. 3 lines with V_LINES=2 → third line produces no writes.
- Short frame: VSYNC rises after 1 of 2 lines → no `frame_done`, `fmt_err`=1, next frame starts at addr 0.
- Abort: reset pulse mid-line, or init_done dropped mid-line → all outputs 0 on the next cycle, no further `pix_we`, and capture resumes only after a full blank→frame sequence.
